// File: rtl/dm_io_intreg_pkg.sv
// Shared constants and helpers for the CPU-internal I/O register bank.
package dm_io_pkg;

  localparam logic [7:0] DM_KEY_VAL   = 8'hd8;
  localparam logic [7:0] DM_SPL_ADDR  = 8'h3d;
  localparam logic [7:0] DM_SPH_ADDR  = 8'h3e;
  localparam logic [7:0] DM_SREG_ADDR = 8'h3f;

  // Unlock counter width; bounds UNLOCK_CYC to 1..15
  localparam int DM_UCNT_W = 4;

  // True when addr falls in [base, base+n-1]
  function automatic bit addr_in_window(input int unsigned addr,
                                        input int unsigned base,
                                        input int unsigned n);
    return (addr >= base) && (addr < base + n);
  endfunction

endpackage

// File: rtl/dm_io_intreg_if.sv
// I/O bus between the data-memory decode (master) and the internal register bank (slave).
interface dm_io_intreg_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] io_addr;
  logic          io_en_i;
  logic          io_we;
  logic [DW-1:0] io_wdata;
  logic          io_en_o;
  logic [DW-1:0] io_rdata;
  logic          io_rvalid;

  modport master (
    output io_addr, io_en_i, io_we, io_wdata,
    input  io_en_o, io_rdata, io_rvalid
  );

  modport slave (
    input  io_addr, io_en_i, io_we, io_wdata,
    output io_en_o, io_rdata, io_rvalid
  );
endinterface

// File: rtl/dm_io_intreg_unlock.sv
// Key-unlocked write window: a correct key opens the window for UNLOCK_CYC cycles,
// one protected write consumes it, a locked protected write raises prot_err.
module dm_unlock_timer
  import dm_io_pkg::*;
#(
  parameter int UNLOCK_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_wr,     // bus write to the key address
  input  logic i_key_match,  // write data equals the key value
  input  logic i_prot_wr,    // bus write to the protected register
  output logic o_unlocked,
  output logic o_prot_ok,    // protected write may proceed this cycle
  output logic o_prot_err
);

  logic [DM_UCNT_W-1:0] r_ucnt;
  logic                 r_prot_err;

  assign o_unlocked = (r_ucnt != '0);
  assign o_prot_ok  = i_prot_wr & o_unlocked;
  assign o_prot_err = r_prot_err;

  // Window counter: key loads/clears, protected write consumes, else count down to 0
  always_ff @(posedge clk) begin
    if (rst)
      r_ucnt <= '0;
    else if (i_key_wr)
      r_ucnt <= i_key_match ? DM_UCNT_W'(UNLOCK_CYC) : '0;
    else if (i_prot_wr)
      r_ucnt <= '0;
    else if (r_ucnt != '0)
      r_ucnt <= r_ucnt - DM_UCNT_W'(1);
  end

  // One-cycle error pulse for a protected write attempted while locked
  always_ff @(posedge clk) begin
    if (rst) r_prot_err <= 1'b0;
    else     r_prot_err <= i_prot_wr & ~o_unlocked;
  end

endmodule

// File: rtl/dm_io_intreg.sv
// Bank of CPU-internal I/O registers (SPL/SPH/SREG...) in a contiguous I/O window.
// Owned addresses (registers + unlock key) are masked from the external peripheral bus.
module dm_io_intreg
  import dm_io_pkg::*;
#(
  parameter int                  AW         = 8,
  parameter int                  DW         = 8,
  parameter int                  NREG       = 3,
  parameter logic [AW-1:0]       BASE_ADDR  = DM_SPL_ADDR,
  parameter logic [NREG*DW-1:0]  RST_VAL    = '0,
  parameter logic [AW-1:0]       KEY_ADDR   = 8'h34,
  parameter logic [DW-1:0]       KEY_VAL    = DM_KEY_VAL,
  parameter int                  PROT_IDX   = NREG,
  parameter int                  UNLOCK_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  dm_io_intreg_if.slave      bus,
  input  logic [NREG-1:0]    hw_we,
  input  logic [NREG*DW-1:0] hw_wdata,
  output logic [NREG*DW-1:0] reg_q,
  output logic               unlocked,
  output logic               prot_err
);

  // Elaboration-time parameter sanity
  if (addr_in_window(int'(KEY_ADDR), int'(BASE_ADDR), NREG)) begin : g_bad_key
    $error("dm_io_intreg: KEY_ADDR lies inside the register window");
  end
  if (UNLOCK_CYC < 1 || UNLOCK_CYC > 15) begin : g_bad_ucyc
    $error("dm_io_intreg: UNLOCK_CYC out of range 1..15");
  end
  if (NREG < 1 || NREG > 16) begin : g_bad_nreg
    $error("dm_io_intreg: NREG out of range 1..16");
  end
  if (PROT_IDX < 0 || PROT_IDX > NREG) begin : g_bad_prot
    $error("dm_io_intreg: PROT_IDX out of range 0..NREG");
  end

  logic [NREG-1:0][DW-1:0] r_reg;
  logic [DW-1:0]           r_rdata;
  logic                    r_rvalid;

  logic [NREG-1:0] w_hit;
  logic [NREG-1:0] w_bus_wr;
  logic            w_key_hit;
  logic            w_own;
  logic            w_prot_wr;
  logic            w_prot_ok;
  logic            w_unlocked;
  logic            w_rd_req;
  logic [DW-1:0]   w_rd_data;

  // Address decode; protected slot is found by loop compare so PROT_IDX=NREG never indexes out of range
  always_comb begin
    w_hit     = '0;
    w_prot_wr = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      w_hit[i] = bus.io_en_i & (bus.io_addr == AW'(int'(BASE_ADDR) + i));
      if (i == PROT_IDX) w_prot_wr = w_hit[i] & bus.io_we;
    end
    w_key_hit = bus.io_en_i & (bus.io_addr == KEY_ADDR);
    w_own     = w_key_hit | (|w_hit);
  end

  assign bus.io_en_o = bus.io_en_i & ~w_own;

  dm_unlock_timer #(
    .UNLOCK_CYC (UNLOCK_CYC)
  ) u_unlock (
    .clk         (clk),
    .rst         (rst),
    .i_key_wr    (w_key_hit & bus.io_we),
    .i_key_match (bus.io_wdata == KEY_VAL),
    .i_prot_wr   (w_prot_wr),
    .o_unlocked  (w_unlocked),
    .o_prot_ok   (w_prot_ok),
    .o_prot_err  (prot_err)
  );

  // Effective bus write per register; a locked protected write is dropped here
  always_comb begin
    w_bus_wr = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i == PROT_IDX) w_bus_wr[i] = w_prot_ok;
      else               w_bus_wr[i] = w_hit[i] & bus.io_we;
    end
  end

  // Register array: bus write has priority over the core-side hw strobe
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst)              r_reg[i] <= RST_VAL[i*DW +: DW];
      else if (w_bus_wr[i]) r_reg[i] <= bus.io_wdata;
      else if (hw_we[i])    r_reg[i] <= hw_wdata[i*DW +: DW];
    end
  end

  // Read mux sees pre-update register values; key address reads back the window state
  always_comb begin
    w_rd_req  = w_own & ~bus.io_we;
    w_rd_data = '0;
    if (w_key_hit) w_rd_data = {{(DW-1){1'b0}}, w_unlocked};
    for (int i = 0; i < NREG; i++)
      if (w_hit[i]) w_rd_data = r_reg[i];
  end

  // Registered read port; data holds between valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_req;
      if (w_rd_req) r_rdata <= w_rd_data;
    end
  end

  assign bus.io_rdata  = r_rdata;
  assign bus.io_rvalid = r_rvalid;
  assign reg_q         = r_reg;
  assign unlocked      = w_unlocked;

endmodule

// File: tb/tb_dm_io_intreg.sv
// Self-checking bench for dm_io_intreg: decode sweep, R/W, conflicts, protection window, reset.
module tb_dm_io_intreg;

  localparam logic [23:0] RST = 24'h02_12_34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  hw_we = '0;
  logic [23:0] hw_wdata = '0;
  logic [23:0] reg_q;
  logic        unlocked;
  logic        prot_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] sb[$];

  dm_io_intreg_if #(.AW(8), .DW(8)) bus ();

  dm_io_intreg #(
    .AW(8), .DW(8), .NREG(3), .BASE_ADDR(8'h3d), .RST_VAL(RST),
    .KEY_ADDR(8'h34), .KEY_VAL(8'hd8), .PROT_IDX(2), .UNLOCK_CYC(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hw_we    (hw_we),
    .hw_wdata (hw_wdata),
    .reg_q    (reg_q),
    .unlocked (unlocked),
    .prot_err (prot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Read scoreboard: every valid pulse must match the oldest expected read
  always @(negedge clk) begin
    if (bus.io_rvalid === 1'b1) begin
      if (sb.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else                chk("rd_data", {24'h0, bus.io_rdata}, {24'h0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.io_en_i = 1'b0; bus.io_we = 1'b0; hw_we = '0;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus.io_en_i = 1'b1; bus.io_we = 1'b1; bus.io_addr = a; bus.io_wdata = d;
    tick(); idle();
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [7:0] exp);
    bus.io_en_i = 1'b1; bus.io_we = 1'b0; bus.io_addr = a;
    sb.push_back(exp);
    tick(); idle();
  endtask

  initial begin
    logic exp_en;
    idle();
    bus.io_addr = '0; bus.io_wdata = '0;

    // Decode sweep (held in reset so owned accesses have no side effects)
    for (int pass = 0; pass < 3; pass++) begin
      bus.io_en_i = (pass != 2);
      bus.io_we   = (pass == 1);
      for (int a = 0; a < 256; a++) begin
        bus.io_addr = 8'(a);
        #1;
        exp_en = (pass != 2) && !(a == 'h34 || (a >= 'h3d && a <= 'h3f));
        chk("decode_en_o", {31'h0, bus.io_en_o}, {31'h0, exp_en});
      end
    end
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("rst_reg_q", {8'h0, reg_q}, {8'h0, RST});
    chk("rst_unlocked", {31'h0, unlocked}, 32'd0);
    chk("rst_rvalid", {31'h0, bus.io_rvalid}, 32'd0);
    chk("rst_prot_err", {31'h0, prot_err}, 32'd0);

    // Basic write/read
    bus_wr(8'h3e, 8'h5a);
    chk("wr_sph", {24'h0, reg_q[15:8]}, 32'h5a);
    bus_rd(8'h3e, 8'h5a);
    chk("rvalid_hi", {31'h0, bus.io_rvalid}, 32'd1);
    tick();
    chk("rvalid_lo", {31'h0, bus.io_rvalid}, 32'd0);

    // Bus vs hw conflict on register 0
    bus.io_en_i = 1'b1; bus.io_we = 1'b1; bus.io_addr = 8'h3d; bus.io_wdata = 8'h11;
    hw_we = 3'b001; hw_wdata = 24'h00_00_22;
    tick(); idle();
    chk("conflict_bus_wins", {24'h0, reg_q[7:0]}, 32'h11);
    hw_we = 3'b001; hw_wdata = 24'h00_00_22;
    tick(); idle();
    chk("hw_only", {24'h0, reg_q[7:0]}, 32'h22);
    hw_we = 3'b011; hw_wdata = 24'h66_55_44;
    tick(); idle();
    chk("hw_multi", {8'h0, reg_q}, {8'h0, 24'h02_55_44});
    // Read sees old value during a same-cycle hw update
    bus.io_en_i = 1'b1; bus.io_we = 1'b0; bus.io_addr = 8'h3d;
    hw_we = 3'b001; hw_wdata = 24'h00_00_77;
    sb.push_back(8'h44);
    tick(); idle();
    chk("hw_during_rd", {24'h0, reg_q[7:0]}, 32'h77);

    // Locked protected write is dropped
    bus_wr(8'h3f, 8'h80);
    chk("locked_reg", {24'h0, reg_q[23:16]}, 32'h02);
    chk("locked_err", {31'h0, prot_err}, 32'd1);
    tick();
    chk("err_pulse_end", {31'h0, prot_err}, 32'd0);

    // Protected write on the last window cycle (4 after key)
    bus_wr(8'h34, 8'hd8);
    chk("unlocked_open", {31'h0, unlocked}, 32'd1);
    tick(); tick(); tick();
    bus_wr(8'h3f, 8'h80);
    chk("win4_reg", {24'h0, reg_q[23:16]}, 32'h80);
    chk("win4_used", {31'h0, unlocked}, 32'd0);
    chk("win4_noerr", {31'h0, prot_err}, 32'd0);

    // One cycle too late
    bus_wr(8'h34, 8'hd8);
    tick(); tick(); tick(); tick();
    bus_wr(8'h3f, 8'h81);
    chk("win5_reg", {24'h0, reg_q[23:16]}, 32'h80);
    chk("win5_err", {31'h0, prot_err}, 32'd1);

    // Wrong key closes an open window
    bus_wr(8'h34, 8'hd8);
    bus_wr(8'h34, 8'h00);
    chk("wrong_key", {31'h0, unlocked}, 32'd0);

    // Re-key on cycle 3 extends the window
    bus_wr(8'h34, 8'hd8);
    tick(); tick();
    bus_wr(8'h34, 8'hd8);
    tick(); tick(); tick();
    chk("rekey_open", {31'h0, unlocked}, 32'd1);
    bus_wr(8'h3f, 8'h42);
    chk("rekey_reg", {24'h0, reg_q[23:16]}, 32'h42);

    // Key register readback, open then expired
    bus_wr(8'h34, 8'hd8);
    bus_rd(8'h34, 8'h01);
    tick(); tick(); tick(); tick();
    bus_rd(8'h34, 8'h00);

    // Reset mid-window with a concurrent bus write and hw strobes
    bus_wr(8'h34, 8'hd8);
    bus_rd(8'h3d, 8'h77);
    rst = 1'b1;
    bus.io_en_i = 1'b1; bus.io_we = 1'b1; bus.io_addr = 8'h3d; bus.io_wdata = 8'h99;
    hw_we = 3'b111; hw_wdata = 24'haa_bb_cc;
    tick(); idle(); rst = 1'b0;
    chk("rst2_reg_q", {8'h0, reg_q}, {8'h0, RST});
    chk("rst2_unlocked", {31'h0, unlocked}, 32'd0);
    chk("rst2_rvalid", {31'h0, bus.io_rvalid}, 32'd0);
    chk("rst2_prot_err", {31'h0, prot_err}, 32'd0);
    bus_wr(8'h3f, 8'h55);
    chk("post_rst_locked", {24'h0, reg_q[23:16]}, 32'h02);
    chk("post_rst_err", {31'h0, prot_err}, 32'd1);

    tick(); tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_io_intreg.md
Name: dm_io_intreg

Overview:
Parametrised bank of CPU-internal I/O-mapped registers (SP low/high, SREG and extensions) occupying a contiguous I/O address window.
- Masks `io_en` for addresses it owns so external peripherals never see them.
- Owns the registers themselves, with a registered read path and core-side hardware update ports.
- Adds an optional key-unlocked, time-windowed write protection on one register.
- Sits between the data-memory/I/O decode and the peripheral bus, beside the core's SP/SREG logic.

Parameters:
- AW, 8, I/O address width
- DW, 8, register data width
- NREG, 3, number of internal registers; range 1..16
- BASE_ADDR, 8'h3d, address of register 0; register i sits at BASE_ADDR+i
- RST_VAL, {NREG*DW{1'b0}}, flattened reset values; register i at bits [i*DW +: DW]
- KEY_ADDR, 8'h34, address of the unlock-key register; must lie outside [BASE_ADDR, BASE_ADDR+NREG-1]
- KEY_VAL, 8'hd8, value that opens the unlock window
- PROT_IDX, NREG, index of the protected register; NREG means no protection
- UNLOCK_CYC, 4, length of the unlock window in cycles; range 1..15

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset; synchronous, active-high
- io_addr, in, AW, I/O register address
- io_en_i, in, 1, I/O access enable
- io_we, in, 1, 1 = write, 0 = read; qualified by io_en_i
- io_wdata, in, DW, bus write data
- io_en_o, out, 1, masked I/O enable to external peripherals
- io_rdata, out, DW, registered read data
- io_rvalid, out, 1, read-data-valid pulse
- hw_we, in, NREG, per-register core-side write strobe
- hw_wdata, in, NREG*DW, per-register core-side write data
- reg_q, out, NREG*DW, current register contents
- unlocked, out, 1, unlock window open
- prot_err, out, 1, 1-cycle pulse on a rejected protected write

Behaviour:
- Decode (combinational):
  - hit_i = io_en_i & (io_addr == BASE_ADDR+i).
  - key_hit = io_en_i & (io_addr == KEY_ADDR).
  - own = key_hit | OR(hit_i).
  - io_en_o = io_en_i & ~own. Zero latency, independent of io_we.
- Reset (rst=1 at a clock edge):
  - reg i <= RST_VAL slice; io_rdata <= 0; io_rvalid <= 0; prot_err <= 0.
  - Unlock counter <= 0, so unlocked = 0.
  - rst overrides every simultaneous write or key event.
  - Reset mid-window closes the window.
- Register write:
  - Bus write (hit_i & io_we) loads io_wdata.
  - Otherwise hw_we[i] loads the hw_wdata slice.
  - Bus write wins over hw_we in the same cycle.
  - reg_q shows the new value one cycle after the write edge.
- Read:
  - hit_i & ~io_we, or key_hit & ~io_we: io_rdata is registered and io_rvalid = 1 on the next cycle.
  - Data is the register value before any same-cycle hw update.
  - Key register reads as {DW-1 zeros, unlocked}.
  - io_rvalid = 0 for non-owned or write accesses.
  - io_rdata holds its last value while io_rvalid = 0.
- Unlock counter (ucnt, 4 bits); unlocked = (ucnt != 0):
  - Key write with io_wdata == KEY_VAL: ucnt <= UNLOCK_CYC. Reloads even if already open.
  - Key write with any other value: ucnt <= 0.
  - Protected write (hit_PROT_IDX & io_we):
    - unlocked = 1: write accepted, ucnt <= 0 (single use).
    - unlocked = 0: write dropped, register unchanged, prot_err = 1 next cycle.
  - Otherwise: ucnt <= ucnt-1 when nonzero; saturates at 0.
  - Window: the protected write is accepted on cycles 1..UNLOCK_CYC after the key-write edge.
- hw_we is never protected. hw_we to the protected index always writes.
- PROT_IDX = NREG: no protected register; key register still decoded, and the counter runs but gates nothing.
- Simultaneous hw_we on several registers: all update independently.

Decomposition:
- Package dm_io_pkg holds:
  - defaults DM_KEY_VAL = 8'hd8, DM_SPL_ADDR = 8'h3d, DM_SPH_ADDR = 8'h3e, DM_SREG_ADDR = 8'h3f
  - localparam function addr_in_window(addr, base, n) for the decoder and assertions
- Sub-module dm_unlock_timer (key compare, ucnt, unlocked, accept/err generation) is natural.
- Decode, register array and read mux stay in the top.
- Elaboration check: KEY_ADDR outside the register window, UNLOCK_CYC within 1..15.

Test Plan:
- Decode: defaults, io_en_i=1, sweep io_addr 0x00..0xFF.
  - Required: io_en_o = 0 only at 0x34 and 0x3d..0x3f; 1 elsewhere.
  - Required: io_en_i=0 gives io_en_o = 0 everywhere.
- Read/write: write 0x5a to 0x3e, then read 0x3e.
  - Required: reg_q[15:8] = 0x5a after 1 cycle.
  - Required: io_rvalid pulses one cycle after the read with io_rdata = 0x5a.
- Conflict: same cycle bus write 0x11 to 0x3d and hw_we[0] = 1 with 0x22.
  - Required: register 0 = 0x11.
  - Required: next cycle hw-only write 0x22 gives 0x22.
- Protection, PROT_IDX = 2:
  - Write 0x80 to 0x3f unlocked → reg unchanged, prot_err pulse.
  - Write 0xd8 to 0x34, then write 0x80 to 0x3f 4 cycles later → accepted, unlocked = 0 afterwards.
  - Same at 5 cycles later → rejected.
- Key edge cases:
  - Wrong key 0x00 written while unlocked → unlocked = 0.
  - Key re-written on cycle 3 → window extends by 4.
  - Read 0x34 while open → io_rdata = 0x01.
- Reset: rst asserted mid-window and concurrent with a bus write.
  - Required: all registers = RST_VAL, unlocked = 0, io_rvalid = 0, prot_err = 0 on the next cycle.
